// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the 4:1 mux scan sequencer.
//   state_e   - sequencer FSM states (IDLE / SCAN / DONE)
//   CH_COUNT  - number of mux channels walked per scan
//   SEL_W     - width of the mux select bus {s1,s0}
//   SETTLE_W  - width of the per-channel settle counter
//   sel_next  - select increment with natural wrap at CH_COUNT
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CH_COUNT = 4;
    localparam int SEL_W    = 2;
    localparam int SETTLE_W = 8;

    // Advance the channel select; the 2-bit width provides the 3 -> 0 wrap.
    function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] sel);
        return sel + {{(SEL_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mux_scan_timer.sv
// mux_scan_timer: per-channel settle timer for the mux scan sequencer.
// Counts the cycles a select value has been held and raises tick during the
// last of SETTLE_CYCLES cycles, so the capture happens on the edge ending it.
// The counter reloads to zero on each channel entry (after a tick), whenever
// the sequencer is not scanning, and on abort.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  asynchronous active-high reset
//   run    in  sequencer is in SCAN
//   abort  in  cancel request; suppresses tick and clears the count
//   tick   out one-cycle capture strobe for the current channel
module mux_scan_timer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic abort,
    output logic tick
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    logic [SETTLE_W-1:0] cnt_r;
    logic                tick_s;

    // Capture strobe: last settle cycle of the current channel, unless aborted.
    always_comb begin
        tick_s = 1'b0;
        if (run && !abort && (cnt_r == SETTLE_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Settle counter: restarts at every channel entry, counts while scanning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {SETTLE_W{1'b0}};
        end else if (!run || abort || tick_s) begin
            cnt_r <= {SETTLE_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(SETTLE_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer driving the select lines of a 4:1 mux. On start it
// walks channels 0..3, holds each select for SETTLE_CYCLES cycles, captures
// mux_out once per channel into a shadow register and publishes the full
// 4-bit snapshot on sample together with a one-cycle done pulse.
// Optional feature (macro MUX_SCAN_CHANGE_EN): keeps the previous completed
// snapshot and raises changed during DONE when the new sample differs from
// it. Without the macro, changed is tied low.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-high reset
//   start    in  scan request, honoured in IDLE only
//   abort    in  synchronous cancel, honoured in SCAN only
//   mux_out  in  output of the scanned mux
//   s1, s0   out registered mux select
//   busy     out high while not IDLE
//   done     out one-cycle pulse, sample freshly updated
//   sample   out bit i = mux_out captured with select i
//   changed  out snapshot-changed flag (DONE cycle only)
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       mux_out,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample,
    output logic       changed
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CH_COUNT - 1);

    state_e                state_r;
    state_e                state_nxt_s;
    logic                  busy_r;
    logic                  done_r;
    logic                  busy_nxt_s;
    logic                  done_nxt_s;
    logic [SEL_W-1:0]      sel_r;
    logic [CH_COUNT-1:0]   shadow_r;
    logic [CH_COUNT-1:0]   sample_r;
    logic [CH_COUNT-1:0]   new_sample_s;
    logic                  run_s;
    logic                  tick_s;
    logic                  last_cap_s;

    assign run_s = (state_r == SCAN);

    mux_scan_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .run   (run_s),
        .abort (abort),
        .tick  (tick_s)
    );

    // Final capture of a scan: tick already excludes an aborting edge.
    assign last_cap_s   = run_s && tick_s && (sel_r == LAST_SEL);
    assign new_sample_s = {mux_out, shadow_r[CH_COUNT-2:0]};

    // FSM state register plus registered busy/done decoded from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic; abort wins over a capture on the same edge.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SCAN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (last_cap_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered above.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
            SCAN: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b0;
            end
            DONE: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Select walk, per-channel capture into shadow, snapshot publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_r    <= {SEL_W{1'b0}};
            shadow_r <= {CH_COUNT{1'b0}};
            sample_r <= {CH_COUNT{1'b0}};
        end else if (run_s) begin
            if (abort) begin
                sel_r    <= {SEL_W{1'b0}};
                shadow_r <= {CH_COUNT{1'b0}};
            end else if (tick_s) begin
                shadow_r[sel_r] <= mux_out;
                sel_r           <= sel_next(sel_r);
                if (last_cap_s) begin
                    sample_r <= new_sample_s;
                end else begin
                    sample_r <= sample_r;
                end
            end else begin
                sel_r <= sel_r;
            end
        end else begin
            // IDLE and DONE park the select at channel 0; a new scan starts clean.
            sel_r <= {SEL_W{1'b0}};
            if ((state_r == IDLE) && start) begin
                shadow_r <= {CH_COUNT{1'b0}};
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    assign s1     = sel_r[1];
    assign s0     = sel_r[0];
    assign busy   = busy_r;
    assign done   = done_r;
    assign sample = sample_r;

`ifdef MUX_SCAN_CHANGE_EN
    logic [CH_COUNT-1:0] prev_r;
    logic                changed_r;

    // Compare each completed snapshot with the previous one; aborted scans
    // never reach last_cap_s and so leave prev_r untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r    <= {CH_COUNT{1'b0}};
            changed_r <= 1'b0;
        end else if (last_cap_s) begin
            prev_r    <= new_sample_s;
            changed_r <= (new_sample_s != prev_r);
        end else begin
            changed_r <= 1'b0;
        end
    end

    assign changed = changed_r;
`else
    assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed self-checking bench for mux_scan_ctrl.
// Three instances (SETTLE_CYCLES = 1, 3, 2) each scan their own behavioural
// 4:1 mux. Expected values are hand-computed constants.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_CHANGE_EN
    localparam logic CHG = 1'b1;
`else
    localparam logic CHG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: S=1
    logic start_a = 1'b0;
    logic [3:0] in_a = 4'b0001;
    logic mux_a, s1_a, s0_a, busy_a, done_a, chg_a;
    logic [3:0] sample_a;
    assign mux_a = in_a[{s1_a, s0_a}];

    // Instance B: S=3
    logic start_b = 1'b0;
    logic [3:0] in_b = 4'b1101;
    logic mux_b, s1_b, s0_b, busy_b, done_b, chg_b;
    logic [3:0] sample_b;
    assign mux_b = in_b[{s1_b, s0_b}];

    // Instance C: S=2
    logic start_c = 1'b0;
    logic abort_c = 1'b0;
    logic [3:0] in_c = 4'b0001;
    logic mux_c, s1_c, s0_c, busy_c, done_c, chg_c;
    logic [3:0] sample_c;
    assign mux_c = in_c[{s1_c, s0_c}];

    mux_scan_ctrl #(.SETTLE_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(1'b0), .mux_out(mux_a),
        .s1(s1_a), .s0(s0_a), .busy(busy_a), .done(done_a),
        .sample(sample_a), .changed(chg_a)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .mux_out(mux_b),
        .s1(s1_b), .s0(s0_b), .busy(busy_b), .done(done_b),
        .sample(sample_b), .changed(chg_b)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(2)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .mux_out(mux_c),
        .s1(s1_c), .s0(s0_c), .busy(busy_c), .done(done_c),
        .sample(sample_c), .changed(chg_c)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    // One S=1 scan on instance A with expected snapshot and change flag.
    task automatic scan_a(input logic [3:0] exp_s, input logic exp_c);
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        chk("a_busy_scan", {3'b000, busy_a}, 4'd1);
        chk("a_chg_scan", {3'b000, chg_a}, 4'd0);
        step(3);
        step(1);
        chk("a_done", {3'b000, done_a}, 4'd1);
        chk("a_sample", sample_a, exp_s);
        chk("a_changed", {3'b000, chg_a}, {3'b000, exp_c});
        step(1);
        chk("a_chg_idle", {3'b000, chg_a}, 4'd0);
        chk("a_busy_idle", {3'b000, busy_a}, 4'd0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1;
        chk("rst_busy", {3'b000, busy_a}, 4'd0);
        chk("rst_done", {3'b000, done_a}, 4'd0);
        chk("rst_sel", {2'b00, s1_a, s0_a}, 4'd0);
        chk("rst_sample", sample_a, 4'd0);
        chk("rst_changed", {3'b000, chg_a}, 4'd0);
        #11;
        rst = 1'b0;
        step(1);

        // ---------------- S=1, inputs 0001 ----------------
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        chk("s1_sel0", {2'b00, s1_a, s0_a}, 4'd0);
        chk("s1_busy", {3'b000, busy_a}, 4'd1);
        for (int c = 1; c < 4; c++) begin
            step(1);
            chk("s1_sel", {2'b00, s1_a, s0_a}, 4'(c));
            chk("s1_nodone", {3'b000, done_a}, 4'd0);
        end
        step(1);
        chk("s1_done", {3'b000, done_a}, 4'd1);
        chk("s1_busy_done", {3'b000, busy_a}, 4'd1);
        chk("s1_sel_done", {2'b00, s1_a, s0_a}, 4'd0);
        chk("s1_sample", sample_a, 4'b0001);
        chk("s1_changed", {3'b000, chg_a}, {3'b000, CHG});
        step(1);
        chk("s1_done_low", {3'b000, done_a}, 4'd0);
        chk("s1_busy_low", {3'b000, busy_a}, 4'd0);

        // ---------------- S=3, inputs 1101, stray start ----------------
        start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        chk("s3_sel0", {2'b00, s1_b, s0_b}, 4'd0);
        for (int c = 1; c < 12; c++) begin
            step(1);
            start_b = (c == 4);
            chk("s3_sel", {2'b00, s1_b, s0_b}, 4'(c / 3));
            chk("s3_nodone", {3'b000, done_b}, 4'd0);
            chk("s3_busy", {3'b000, busy_b}, 4'd1);
        end
        step(1);
        chk("s3_done", {3'b000, done_b}, 4'd1);
        chk("s3_sample", sample_b, 4'b1101);
        chk("s3_changed", {3'b000, chg_b}, {3'b000, CHG});
        step(1);
        chk("s3_idle", {3'b000, busy_b}, 4'd0);
        step(1);
        chk("s3_no_restart", {3'b000, busy_b}, 4'd0);

        // ---------------- S=2, full scan then abort ----------------
        start_c = 1'b1;
        step(1);
        start_c = 1'b0;
        step(7);
        chk("s2_nodone7", {3'b000, done_c}, 4'd0);
        step(1);
        chk("s2_done", {3'b000, done_c}, 4'd1);
        chk("s2_sample", sample_c, 4'b0001);
        step(1);
        in_c = 4'b1110;
        start_c = 1'b1;
        step(1);
        start_c = 1'b0;
        step(4);
        chk("s2_sel_pre_abort", {2'b00, s1_c, s0_c}, 4'd2);
        abort_c = 1'b1;
        step(1);
        abort_c = 1'b0;
        chk("s2_abort_busy", {3'b000, busy_c}, 4'd0);
        chk("s2_abort_sel", {2'b00, s1_c, s0_c}, 4'd0);
        chk("s2_abort_done", {3'b000, done_c}, 4'd0);
        for (int c = 0; c < 8; c++) begin
            step(1);
            chk("s2_no_done", {3'b000, done_c}, 4'd0);
            chk("s2_sample_kept", sample_c, 4'b0001);
        end
        in_c = 4'b0110;
        start_c = 1'b1;
        step(1);
        start_c = 1'b0;
        step(7);
        chk("s2b_busy", {3'b000, busy_c}, 4'd1);
        step(1);
        chk("s2b_done", {3'b000, done_c}, 4'd1);
        chk("s2b_sample", sample_c, 4'b0110);
        chk("s2b_changed", {3'b000, chg_c}, {3'b000, CHG});
        step(1);

        // ---------------- async reset mid-scan (S=3, sel=2) ----------------
        start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        step(6);
        chk("rs_sel2", {2'b00, s1_b, s0_b}, 4'd2);
        chk("rs_sample_pre", sample_b, 4'b1101);
        #2;
        rst = 1'b1;
        #1;
        chk("rs_busy", {3'b000, busy_b}, 4'd0);
        chk("rs_done", {3'b000, done_b}, 4'd0);
        chk("rs_sel", {2'b00, s1_b, s0_b}, 4'd0);
        chk("rs_sample", sample_b, 4'd0);
        step(1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            step(1);
            chk("rs_no_done", {3'b000, done_b}, 4'd0);
        end

        // ---------------- change-flag sequence on instance A ----------------
        in_a = 4'b1010;
        scan_a(4'b1010, CHG);
        scan_a(4'b1010, 1'b0);
        in_a[1] = 1'b1;
        scan_a(4'b1010, 1'b0);
        in_a[0] = 1'b1;
        scan_a(4'b1011, CHG);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
